// File: rtl/piso_word_serializer_pkg.sv
// Shared encodings and helpers for the parallel-in serial-out word serializer.
package piso_word_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int unsigned GAP_CNT_W = 4;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_word_serializer_if.sv
// Parallel word handshake plus serial output qualifiers of the serializer.
interface piso_word_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Data_Valid_In;
    logic                  Data_Ready_Out;
    logic                  Serial_Data_Out;
    logic                  Serial_Valid_Out;
    logic                  Frame_Start_Out;
    logic                  Busy_Out;

    modport master (
        output Data_In,
        output Data_Valid_In,
        input  Data_Ready_Out,
        input  Serial_Data_Out,
        input  Serial_Valid_Out,
        input  Frame_Start_Out,
        input  Busy_Out
    );

    modport slave (
        input  Data_In,
        input  Data_Valid_In,
        output Data_Ready_Out,
        output Serial_Data_Out,
        output Serial_Valid_Out,
        output Frame_Start_Out,
        output Busy_Out
    );
endinterface

// File: rtl/piso_shift_core.sv
// Loadable shift register with selectable bit order; zeros shift in behind the word
// so the tap reads 0 once a word has fully drained.
module piso_shift_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_tap
);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shifted;

    if (LSB_FIRST) begin : g_lsb
        assign w_shifted = {1'b0, r_shreg[DATA_WIDTH-1:1]};
        assign o_tap     = r_shreg[0];
    end else begin : g_msb
        assign w_shifted = {r_shreg[DATA_WIDTH-2:0], 1'b0};
        assign o_tap     = r_shreg[DATA_WIDTH-1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else begin
            r_shreg <= w_shifted;
        end
    end

endmodule

// File: rtl/piso_word_serializer.sv
// Word serializer: one-word holding buffer, IDLE/SHIFT/GAP sequencer and counters
// feeding a shift core; every output comes straight from a flop.
module piso_word_serializer
    import piso_word_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned IDLE_GAP   = 0
) (
    input  logic                 Clk_In,
    input  logic                 Reset_In,
    piso_word_serializer_if.slave bus_if
);

    localparam int unsigned          CNT_W    = clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  r_buf_full;
    logic                  r_ready;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [GAP_CNT_W-1:0]  r_gap_cnt;
    logic                  r_ser_valid;
    logic                  r_frame_start;
    logic                  r_busy;

    logic [1:0]            w_state_n;
    logic                  w_buf_full_n;
    logic [CNT_W-1:0]      w_bit_cnt_n;
    logic [GAP_CNT_W-1:0]  w_gap_cnt_n;
    logic                  w_ser_valid_n;
    logic                  w_frame_start_n;
    logic                  w_busy_n;
    logic                  w_accept;
    logic                  w_try_load;
    logic                  w_load;
    logic                  w_tap;

    // Next-state and next-output decode; a finished word or gap falls into the shared load decision.
    always_comb begin
        w_state_n       = r_state;
        w_bit_cnt_n     = r_bit_cnt;
        w_gap_cnt_n     = r_gap_cnt;
        w_ser_valid_n   = 1'b0;
        w_frame_start_n = 1'b0;
        w_try_load      = 1'b0;
        w_load          = 1'b0;
        w_accept        = bus_if.Data_Valid_In & r_ready;

        case (r_state)
            ST_IDLE: begin
                w_try_load = 1'b1;
            end
            ST_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    if (IDLE_GAP != 0) begin
                        w_state_n   = ST_GAP;
                        w_gap_cnt_n = '0;
                    end else begin
                        w_try_load = 1'b1;
                    end
                end else begin
                    w_bit_cnt_n   = r_bit_cnt + CNT_W'(1);
                    w_ser_valid_n = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == LAST_GAP) begin
                    w_try_load = 1'b1;
                end else begin
                    w_gap_cnt_n = r_gap_cnt + GAP_CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_try_load) begin
            w_bit_cnt_n = '0;
            if (r_buf_full) begin
                w_load          = 1'b1;
                w_state_n       = ST_SHIFT;
                w_ser_valid_n   = 1'b1;
                w_frame_start_n = 1'b1;
            end else begin
                w_state_n = ST_IDLE;
            end
        end

        // Load needs a full buffer and accept needs an empty one, so they never coincide.
        if (w_load) begin
            w_buf_full_n = 1'b0;
        end else if (w_accept) begin
            w_buf_full_n = 1'b1;
        end else begin
            w_buf_full_n = r_buf_full;
        end

        w_busy_n = (w_state_n != ST_IDLE) || w_buf_full_n;
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state       <= ST_IDLE;
            r_buf_full    <= 1'b0;
            r_ready       <= 1'b1;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_buf_full    <= w_buf_full_n;
            r_ready       <= ~w_buf_full_n;
            r_bit_cnt     <= w_bit_cnt_n;
            r_gap_cnt     <= w_gap_cnt_n;
            r_ser_valid   <= w_ser_valid_n;
            r_frame_start <= w_frame_start_n;
            r_busy        <= w_busy_n;
        end
    end

    // Holding buffer payload; only meaningful while r_buf_full is set.
    always_ff @(posedge Clk_In) begin
        if (w_accept) begin
            r_buf_data <= bus_if.Data_In;
        end
    end

    piso_shift_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift_core (
        .i_clk  (Clk_In),
        .i_rst  (Reset_In),
        .i_load (w_load),
        .i_data (r_buf_data),
        .o_tap  (w_tap)
    );

    assign bus_if.Data_Ready_Out   = r_ready;
    assign bus_if.Serial_Data_Out  = w_tap;
    assign bus_if.Serial_Valid_Out = r_ser_valid;
    assign bus_if.Frame_Start_Out  = r_frame_start;
    assign bus_if.Busy_Out         = r_busy;

endmodule

// File: tb/tb_piso_word_serializer.sv
// Directed bench for piso_word_serializer: four configurations, word scoreboard on accepts.
module tb_piso_word_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_word_serializer_if #(.DATA_WIDTH(8)) b0 ();
    piso_word_serializer_if #(.DATA_WIDTH(8)) b1 ();
    piso_word_serializer_if #(.DATA_WIDTH(8)) b2 ();
    piso_word_serializer_if #(.DATA_WIDTH(4)) b3 ();

    piso_word_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_GAP(0)) dut0 (.Clk_In(clk), .Reset_In(rst), .bus_if(b0));
    piso_word_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_GAP(2)) dut1 (.Clk_In(clk), .Reset_In(rst), .bus_if(b1));
    piso_word_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .IDLE_GAP(0)) dut2 (.Clk_In(clk), .Reset_In(rst), .bus_if(b2));
    piso_word_serializer #(.DATA_WIDTH(4), .LSB_FIRST(1'b1), .IDLE_GAP(0)) dut3 (.Clk_In(clk), .Reset_In(rst), .bus_if(b3));

    wire [3:0] m_vin   = {b3.Data_Valid_In,    b2.Data_Valid_In,    b1.Data_Valid_In,    b0.Data_Valid_In};
    wire [3:0] m_rdy   = {b3.Data_Ready_Out,   b2.Data_Ready_Out,   b1.Data_Ready_Out,   b0.Data_Ready_Out};
    wire [3:0] m_valid = {b3.Serial_Valid_Out, b2.Serial_Valid_Out, b1.Serial_Valid_Out, b0.Serial_Valid_Out};
    wire [3:0] m_data  = {b3.Serial_Data_Out,  b2.Serial_Data_Out,  b1.Serial_Data_Out,  b0.Serial_Data_Out};
    wire [3:0] m_fs    = {b3.Frame_Start_Out,  b2.Frame_Start_Out,  b1.Frame_Start_Out,  b0.Frame_Start_Out};
    wire [3:0] m_busy  = {b3.Busy_Out,         b2.Busy_Out,         b1.Busy_Out,         b0.Busy_Out};
    logic [31:0] m_din [4];
    assign m_din[0] = 32'(b0.Data_In);
    assign m_din[1] = 32'(b1.Data_In);
    assign m_din[2] = 32'(b2.Data_In);
    assign m_din[3] = 32'(b3.Data_In);

    int checks   = 0;
    int failures = 0;

    logic [31:0] sbq [4][$];
    logic [31:0] cur [4];
    int          bidx [4];
    int          run [4];
    int          last_run [4];

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic int wid(input int id);
        return (id == 3) ? 4 : 8;
    endfunction

    function automatic bit lsb_first(input int id);
        return id != 2;
    endfunction

    function automatic logic exp_bit(input logic [31:0] w, input int width, input bit lsb, input int idx);
        return lsb ? w[idx] : w[width - 1 - idx];
    endfunction

    task automatic drive(input int id, input logic v, input logic [31:0] d);
        case (id)
            0:       begin b0.Data_Valid_In = v; b0.Data_In = d[7:0]; end
            1:       begin b1.Data_Valid_In = v; b1.Data_In = d[7:0]; end
            2:       begin b2.Data_Valid_In = v; b2.Data_In = d[7:0]; end
            default: begin b3.Data_Valid_In = v; b3.Data_In = d[3:0]; end
        endcase
    endtask

    // Offer a word from a negedge, hold until accepted, end at the negedge after acceptance.
    task automatic send(input int id, input logic [31:0] d, output int waits);
        waits = 0;
        drive(id, 1'b1, d);
        while (!m_rdy[id] && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk($sformatf("send%0d_accept_in_time", id), 32'(waits < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(id, 1'b0, 'x);
    endtask

    // Record every accepted word as an expected frame.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (m_vin[k] && m_rdy[k]) sbq[k].push_back(m_din[k]);
            end
        end
    end

    // Compare serial output bit by bit against the expected frames.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                sbq[k].delete();
                bidx[k] = 0;
                run[k]  = 0;
            end else if (m_valid[k]) begin
                if (bidx[k] == 0) begin
                    chk($sformatf("sb%0d_word_pending", k), 32'(sbq[k].size() != 0), 32'd1);
                    if (sbq[k].size() != 0) cur[k] = sbq[k].pop_front();
                    else cur[k] = '0;
                end
                chk($sformatf("sb%0d_bit%0d", k, bidx[k]), 32'(m_data[k]),
                    32'(exp_bit(cur[k], wid(k), lsb_first(k), bidx[k])));
                chk($sformatf("sb%0d_frame_start%0d", k, bidx[k]), 32'(m_fs[k]), 32'(bidx[k] == 0));
                bidx[k] = (bidx[k] == wid(k) - 1) ? 0 : bidx[k] + 1;
                run[k]  = run[k] + 1;
            end else begin
                if (run[k] != 0) last_run[k] = run[k];
                run[k] = 0;
                chk($sformatf("sb%0d_idle_outputs", k), 32'({m_data[k], m_fs[k]}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int gap;
        bit seen;
        for (int k = 0; k < 4; k++) begin
            last_run[k] = 0;
            drive(k, 1'b0, 'x);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state of every instance
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst%0d_ready", k), 32'(m_rdy[k]), 32'd1);
            chk($sformatf("rst%0d_outputs", k), 32'({m_valid[k], m_data[k], m_fs[k], m_busy[k]}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single word latency: nothing after accept edge N, first bit after N+1
        send(0, 32'hA5, w);
        chk("t1_no_bit_after_N", 32'(m_valid[0]), 32'd0);
        chk("t1_busy_after_accept", 32'(m_busy[0]), 32'd1);
        @(negedge clk);
        chk("t1_first_valid", 32'(m_valid[0]), 32'd1);
        chk("t1_first_bit", 32'(m_data[0]), 32'd1);
        chk("t1_first_frame_start", 32'(m_fs[0]), 32'd1);
        repeat (10) @(negedge clk);
        chk("t1_run_len", 32'(last_run[0]), 32'd8);
        chk("t1_idle_busy", 32'(m_busy[0]), 32'd0);

        // Back-to-back words stream without a gap
        send(0, 32'hA5, w);
        send(0, 32'h3C, w);
        chk("t2_second_wait", 32'(w), 32'd1);
        repeat (20) @(negedge clk);
        chk("t2_run_len", 32'(last_run[0]), 32'd16);

        // Forced two-cycle gap, busy held across it
        send(1, 32'h5A, w);
        send(1, 32'hC3, w);
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            chk("t3_busy", 32'(m_busy[1]), 32'd1);
            if (m_fs[1]) seen = 1'b1;
            else if (!m_valid[1]) gap++;
        end
        chk("t3_second_frame_seen", 32'(seen), 32'd1);
        chk("t3_gap_len", 32'(gap), 32'd2);
        repeat (12) @(negedge clk);
        chk("t3_run_len", 32'(last_run[1]), 32'd8);
        chk("t3_idle_busy", 32'(m_busy[1]), 32'd0);

        // Backpressure: third word waits for the buffer to drain
        send(0, 32'h11, w);
        send(0, 32'h22, w);
        send(0, 32'h33, w);
        chk("t4_third_wait", 32'(w), 32'd7);
        repeat (30) @(negedge clk);
        chk("t4_run_len", 32'(last_run[0]), 32'd24);

        // Reset mid-word discards the word
        send(0, 32'hFF, w);
        repeat (4) @(negedge clk);
        chk("t5_fourth_bit_valid", 32'(m_valid[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_outputs", 32'({m_valid[0], m_data[0], m_fs[0], m_busy[0]}), 32'd0);
        chk("t5_async_ready", 32'(m_rdy[0]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_no_resume", 32'(m_valid[0]), 32'd0);
        end
        chk("t5_ready_after_release", 32'(m_rdy[0]), 32'd1);

        // MSB-first and 4-bit configurations
        send(2, 32'h0F, w);
        send(3, 32'h9, w);
        repeat (12) @(negedge clk);
        chk("t6_msb_run_len", 32'(last_run[2]), 32'd8);
        chk("t6_w4_run_len", 32'(last_run[3]), 32'd4);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("end%0d_queue_empty", k), 32'(sbq[k].size()), 32'd0);
            chk($sformatf("end%0d_word_complete", k), 32'(bidx[k]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_word_serializer.md
Name: piso_word_serializer

Overview:
Transmit-side serializer. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, with per-bit valid and frame-start qualifiers. It feeds serial shift chains and serial links in the design, and is the producer end of the serial data path. A one-word holding buffer allows back-to-back words to stream with no idle bit between them.

Parameters:
DATA_WIDTH, 8, word width in bits; legal values are 2 to 32.
LSB_FIRST, 1, bit order: 1 sends bit 0 first, 0 sends bit DATA_WIDTH-1 first.
IDLE_GAP, 0, forced idle cycles between consecutive words; legal values are 0 to 15.

Ports:
Clk_In  input  1  clock; all state updates on the rising edge.
Reset_In  input  1  reset, asynchronous, active-high.
Data_In  input  DATA_WIDTH  parallel word to transmit.
Data_Valid_In  input  1  Data_In is valid.
Data_Ready_Out  output  1  holding buffer empty; a word is accepted when valid and ready are both high at a rising edge.
Serial_Data_Out  output  1  current serial bit, registered.
Serial_Valid_Out  output  1  Serial_Data_Out carries a data bit this cycle.
Frame_Start_Out  output  1  high on the first bit of each word.
Busy_Out  output  1  high when the state is not IDLE or the holding buffer is full.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word):
  - Serial_Data_Out=0, Serial_Valid_Out=0, Frame_Start_Out=0, Busy_Out=0, Data_Ready_Out=1.
  - Holding buffer is emptied, state goes to IDLE, counters go to 0.
  - Any partial word is discarded; no resume after reset.
- Handshake:
  - Data_Ready_Out = NOT buf_full, driven directly from a register with no combinational path from Data_Valid_In.
  - A word is accepted into the holding buffer at an edge where Data_Valid_In=1 and Data_Ready_Out=1.
  - Upstream holds Data_In stable while valid is high and ready is low.
- States: IDLE, SHIFT, GAP.
  - IDLE: if buf_full, load the shifter from the buffer, clear buf_full, present the first bit, set Frame_Start_Out=1, set bit_cnt=0, go to SHIFT.
  - SHIFT: each edge presents the next bit and increments bit_cnt. When the last bit (bit_cnt=DATA_WIDTH-1) is on the output at an edge:
    - IDLE_GAP>0: go to GAP.
    - IDLE_GAP=0 and buf_full: load the next word directly (stays in SHIFT, Frame_Start_Out=1).
    - Otherwise: go to IDLE.
  - GAP: outputs idle for exactly IDLE_GAP cycles, then follows the same load/IDLE decision as above.
- Idle outputs: Serial_Data_Out=0, Serial_Valid_Out=0, Frame_Start_Out=0.
- Latency:
  - A word accepted at edge N while IDLE with the buffer empty has its first bit visible after edge N+1.
  - Its bits occupy cycles N+1 through N+DATA_WIDTH.
- Throughput: with IDLE_GAP=0 and the buffer refilled during the shift, valid bits are continuous and Frame_Start_Out pulses every DATA_WIDTH cycles.
- Simultaneous buffer-to-shifter transfer and new offer: ready was low (buffer full), so the offer is not taken; ready rises on the next cycle. No word is lost or duplicated.
- Bit order:
  - LSB_FIRST=1: shift right, output bit 0.
  - LSB_FIRST=0: shift left, output bit DATA_WIDTH-1.
- Counter widths: bit_cnt is clog2(DATA_WIDTH) bits and never exceeds DATA_WIDTH-1; gap_cnt is 4 bits.
- Data_Valid_In without ready has no effect. X on Data_In while valid is low is ignored.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and a clog2 function.
- One natural sub-module, piso_shift_core: load/shift register with direction select, DATA_WIDTH parallel load, serial output tap.
- Handshake, holding buffer, FSM and counters stay in the top.

Test Plan:
1. Reset, then 0xA5 with LSB_FIRST=1 -> serial bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles; Frame_Start_Out only on the first; first bit after edge N+1.
2. 0xA5 then 0x3C offered back-to-back, IDLE_GAP=0 -> 16 continuous valid cycles; Frame_Start_Out at cycles 1 and 9; second word reads 0,0,1,1,1,1,0,0.
3. IDLE_GAP=2 with two words -> exactly 2 cycles of Serial_Valid_Out=0 between them; Busy_Out high throughout.
4. Backpressure: hold valid high with a third word while the buffer is full -> Data_Ready_Out=0 until the buffer transfers; all three words are emitted in order, none dropped or repeated.
5. Assert Reset_In after the 4th bit of 0xFF -> outputs go to 0 immediately; the word is not resumed; Data_Ready_Out=1 after release.
6. LSB_FIRST=0, word 0x0F -> serial 0,0,0,0,1,1,1,1; DATA_WIDTH=4 with 0x9 -> 1,0,0,1 (LSB_FIRST=1).
